// File: rtl/axi2apb_pkg.sv
// axi2apb_pkg: response codes, burst/state encodings and per-beat address stepping for the AXI-to-APB bridge.
package axi2apb_pkg;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;
   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
   typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP} state_e;
   // Callers truncate to their address width, giving modulo-2^ADDR_WIDTH arithmetic.
   function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                             input logic [3:0] len, input logic [1:0] burst);
      logic [63:0] inc, cont;
      inc  = addr + (64'd1 << size);
      cont = (64'(len) + 64'd1) << size;
      return burst == FIXED ? addr :
             burst == WRAP  ? (addr & ~(cont - 64'd1)) | (inc & (cont - 64'd1)) : inc;
   endfunction
endpackage

// File: rtl/axi2apb_multi_bridge_decoder.sv
// apb_slave_decoder: maps an address to a one-hot APB select; the lowest matching slot wins.
module apb_slave_decoder #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SLV = 4,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = '0,
   parameter logic [ADDR_WIDTH-1:0] SLV_MASK = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLV-1:0]    sel,
   output logic                  hit
);
   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = NUM_SLV - 1; i >= 0; i--)
         if ((addr & SLV_MASK) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            sel    = '0;
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
   end
endmodule

// File: rtl/axi2apb_multi_bridge.sv
// axi2apb_multi_bridge: AXI3-subset slave to multi-slave APB4 master, one APB transfer per beat.
// Define AXI2APB_WRAP_EN to execute WRAP bursts; otherwise WRAP bursts answer SLVERR on every beat.
module axi2apb_multi_bridge
   import axi2apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH = 4,
   parameter int NUM_SLV = 4,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = {32'h0004_F000, 32'h0003_F000, 32'h0002_F000, 32'h0001_F000},
   parameter logic [ADDR_WIDTH-1:0] SLV_MASK = 32'hFFFF_F000,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ID_WIDTH-1:0]     awid_i,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   input  logic [3:0]              awlen_i,
   input  logic [2:0]              awsize_i,
   input  logic [1:0]              awburst_i,
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic                    wlast_i,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   output logic [ID_WIDTH-1:0]     bid_o,
   output logic [1:0]              bresp_o,
   output logic                    bvalid_o,
   input  logic                    bready_i,
   input  logic [ID_WIDTH-1:0]     arid_i,
   input  logic [ADDR_WIDTH-1:0]   araddr_i,
   input  logic [3:0]              arlen_i,
   input  logic [2:0]              arsize_i,
   input  logic [1:0]              arburst_i,
   input  logic                    arvalid_i,
   output logic                    arready_o,
   output logic [ID_WIDTH-1:0]     rid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic                    rlast_o,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   output logic                    pwrite_o,
   output logic                    penable_o,
   output logic [NUM_SLV-1:0]      psel_o,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pready_i,
   input  logic                    pslverr_i
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int SZ_MAX = $clog2(DATA_WIDTH / 8);
   state_e state, state_n;
   logic wr, last_w, hit, wrap_err, err, grant_w, grant_r, done, tout, last, fin, adv, unused_ok;
   logic [ID_WIDTH-1:0] id;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0] len, cnt;
   logic [2:0] size;
   logic [1:0] burst, resp, rresp, bres;
   logic [DATA_WIDTH-1:0] rdata, wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic [TW-1:0] tcnt;
   logic [NUM_SLV-1:0] sel;
   logic [63:0] nxt;
   apb_slave_decoder #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_SLV(NUM_SLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
      u_dec (.addr(addr), .sel(sel), .hit(hit));
`ifdef AXI2APB_WRAP_EN
   assign wrap_err = burst == WRAP && !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
`else
   assign wrap_err = burst == WRAP;
`endif
   // SETUP doubles as the per-beat decision cycle: a faulty beat never drives psel.
   assign err      = !hit || size > 3'(SZ_MAX) || wrap_err;
   assign tout     = tcnt == TW'(TIMEOUT_CYC - 1);
   assign done     = state == ACCESS && (pready_i || tout);
   assign fin      = (state == SETUP && err) || done;
   assign bres     = state == SETUP ? (hit ? SLVERR : DECERR) : (pready_i && !pslverr_i ? OKAY : SLVERR);
   assign last     = cnt == len;
   assign adv      = !last && ((fin && wr) || (state == RDATA && rready_i));
   assign grant_w  = state == IDLE && awvalid_i && (!arvalid_i || !last_w);
   assign grant_r  = state == IDLE && arvalid_i && !grant_w;
   assign nxt      = next_addr({{(64-ADDR_WIDTH){1'b0}}, addr}, size, len, burst);
   assign unused_ok = &{1'b0, wlast_i, nxt[63:ADDR_WIDTH]};
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = grant_w ? WDATA : grant_r ? SETUP : IDLE;
         WDATA:   state_n = wvalid_i ? SETUP : WDATA;
         SETUP:   state_n = !err ? ACCESS : wr ? (last ? BRESP : WDATA) : RDATA;
         ACCESS:  state_n = !done ? ACCESS : wr ? (last ? BRESP : WDATA) : RDATA;
         RDATA:   state_n = !rready_i ? RDATA : last ? IDLE : SETUP;
         BRESP:   state_n = bready_i ? IDLE : BRESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         wr     <= 1'b0;
         last_w <= 1'b0;
         id     <= '0;
         addr   <= '0;
         len    <= '0;
         size   <= '0;
         burst  <= '0;
         cnt    <= '0;
         resp   <= OKAY;
         rresp  <= OKAY;
         rdata  <= '0;
         wdata  <= '0;
         wstrb  <= '0;
         tcnt   <= '0;
      end else begin
         state <= state_n;
         tcnt  <= state == ACCESS ? tcnt + TW'(1) : '0;
         if (grant_w || grant_r) begin
            wr     <= grant_w;
            last_w <= grant_w;
            id     <= grant_w ? awid_i : arid_i;
            addr   <= grant_w ? awaddr_i : araddr_i;
            len    <= grant_w ? awlen_i : arlen_i;
            size   <= grant_w ? awsize_i : arsize_i;
            burst  <= grant_w ? awburst_i : arburst_i;
            cnt    <= '0;
            resp   <= OKAY;
            wstrb  <= '0;
         end
         if (state == WDATA && wvalid_i) begin
            wdata <= wdata_i;
            wstrb <= wstrb_i;
         end
         if (fin) begin
            rresp <= bres;
            rdata <= state == ACCESS && pready_i ? prdata_i : '0;
            if (bres > resp) resp <= bres;
         end
         if (adv) begin
            addr <= nxt[ADDR_WIDTH-1:0];
            cnt  <= cnt + 4'd1;
         end
      end
   assign awready_o = grant_w;
   assign arready_o = grant_r;
   assign wready_o  = state == WDATA;
   assign bvalid_o  = state == BRESP;
   assign bresp_o   = resp;
   assign bid_o     = id;
   assign rvalid_o  = state == RDATA;
   assign rlast_o   = state == RDATA && last;
   assign rdata_o   = rdata;
   assign rresp_o   = rresp;
   assign rid_o     = id;
   assign psel_o    = (state == SETUP || state == ACCESS) && !err ? sel : '0;
   assign penable_o = state == ACCESS;
   assign paddr_o   = addr;
   assign pwrite_o  = wr;
   assign pwdata_o  = wdata;
   assign pstrb_o   = wstrb;
endmodule

// File: tb/tb_axi2apb_multi_bridge.sv
// tb_axi2apb_multi_bridge: directed bench for axi2apb_multi_bridge with a zero-wait APB slave model.
module tb_axi2apb_multi_bridge;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic [3:0] awid_i, arid_i, bid_o, rid_o, wstrb_i, pstrb_o, psel_o, r_id;
   logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o, paddr_o, pwdata_o, prdata_i;
   logic [3:0] awlen_i, arlen_i;
   logic [2:0] awsize_i, arsize_i;
   logic [1:0] awburst_i, arburst_i, bresp_o, rresp_o, b_resp;
   logic awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
   logic arvalid_i, arready_o, rlast_o, rvalid_o, rready_i, pwrite_o, penable_o, pready_i, pslverr_i;
   logic hold_low = 1'b0;
   logic [123:0] outs;
   logic [31:0] apb_addr[$], apb_wd[$];
   logic [3:0] apb_sel[$];
   logic [31:0] r_data[16];
   logic [1:0] r_resp[16];
   logic r_last[16];
   int n_cmp = 0, n_err = 0, cyc = 0, apb_n = 0, err_at = -1, psel_cyc = 0, dly = 0, s = 0, pc = 0;
   axi2apb_multi_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
      .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
      .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pwrite_o(pwrite_o), .penable_o(penable_o),
      .psel_o(psel_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );
   assign outs = {awready_o, wready_o, bvalid_o, bid_o, bresp_o, arready_o, rvalid_o, rid_o, rdata_o, rresp_o,
                  rlast_o, paddr_o, pwdata_o, pstrb_o, pwrite_o, penable_o, psel_o};
   assign pready_i  = !hold_low;
   assign pslverr_i = penable_o && apb_n == err_at;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (|psel_o) psel_cyc <= psel_cyc + 1;
      if (penable_o && pready_i) begin
         apb_addr.push_back(paddr_o);
         apb_wd.push_back(pwdata_o);
         apb_sel.push_back(psel_o);
         apb_n <= apb_n + 1;
      end
   end
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic rd(input logic [31:0] a, input logic [3:0] l, input logic [2:0] sz, input logic [1:0] b);
      int t0;
      arid_i = 4'h5; araddr_i = a; arlen_i = l; arsize_i = sz; arburst_i = b; arvalid_i = 1'b1;
      #1;
      for (int i = 0; i < 50 && !arready_o; i++) tick;
      chk("arready", arready_o, 1'b1);
      tick;
      t0 = cyc;
      arvalid_i = 1'b0;
      for (int k = 0; k <= int'(l); k++) begin
         for (int i = 0; i < 60 && !rvalid_o; i++) tick;
         chk("rvalid", rvalid_o, 1'b1);
         if (k == 0) dly = cyc - t0;
         r_data[k] = rdata_o; r_resp[k] = rresp_o; r_last[k] = rlast_o; r_id = rid_o;
         tick;
      end
   endtask
   task automatic wr(input logic [31:0] a, input logic [3:0] l);
      int t0;
      awid_i = 4'h9; awaddr_i = a; awlen_i = l; awsize_i = 3'd2; awburst_i = 2'b01; awvalid_i = 1'b1;
      #1;
      for (int i = 0; i < 50 && !awready_o; i++) tick;
      chk("awready", awready_o, 1'b1);
      tick;
      t0 = cyc;
      awvalid_i = 1'b0;
      for (int k = 0; k <= int'(l); k++) begin
         wdata_i = 32'hC0DE_0000 + k; wstrb_i = 4'hF; wlast_i = k == int'(l); wvalid_i = 1'b1;
         for (int i = 0; i < 60 && !wready_o; i++) tick;
         chk("wready", wready_o, 1'b1);
         tick;
      end
      wvalid_i = 1'b0; wlast_i = 1'b0;
      for (int i = 0; i < 60 && !bvalid_o; i++) tick;
      chk("bvalid", bvalid_o, 1'b1);
      dly = cyc - t0;
      b_resp = bresp_o;
      tick;
   endtask
   initial begin
      {awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i} = '0;
      {arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i} = '0;
      {wdata_i, wstrb_i, wlast_i, wvalid_i} = '0;
      rready_i = 1'b1; bready_i = 1'b1; prdata_i = 32'hA5A5_0001;
      repeat (3) tick;
      chk("reset_outputs", outs, '0);
      rst_n = 1'b1;
      tick;
      awid_i = 4'h3; awaddr_i = 32'h0001_F010; awlen_i = 0; awsize_i = 3'd2; awburst_i = 2'b01; awvalid_i = 1'b1;
      arid_i = 4'h4; araddr_i = 32'h0002_F000; arlen_i = 0; arsize_i = 3'd2; arburst_i = 2'b01; arvalid_i = 1'b1;
      #1;
      chk("arb1_write_first", {awready_o, arready_o}, 2'b10);
      tick;
      pc = cyc;
      awvalid_i = 1'b0;
      wdata_i = 32'h1234_5678; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
      for (int i = 0; i < 20 && !wready_o; i++) tick;
      tick;
      wvalid_i = 1'b0;
      for (int i = 0; i < 20 && !bvalid_o; i++) tick;
      chk("wr_bvalid_latency", cyc - pc, 3);
      chk("wr_bresp_bid", {bresp_o, bid_o}, {2'b00, 4'h3});
      chk("wr_apb_beat", {apb_addr[$], apb_wd[$], apb_sel[$]}, {32'h0001_F010, 32'h1234_5678, 4'b0001});
      awvalid_i = 1'b1;
      tick;
      chk("arb2_read_next", {awready_o, arready_o}, 2'b01);
      tick;
      arvalid_i = 1'b0; awvalid_i = 1'b0;
      for (int i = 0; i < 20 && !rvalid_o; i++) tick;
      chk("arb2_read_done", {rvalid_o, rresp_o, rid_o}, {1'b1, 2'b00, 4'h4});
      tick;
      rd(32'h0002_F004, 4'd0, 3'd2, 2'b01);
      chk("rd_latency", dly, 2);
      chk("rd_beat", {r_data[0], r_resp[0], r_last[0], r_id}, {32'hA5A5_0001, 2'b00, 1'b1, 4'h5});
      chk("rd_psel", {apb_addr[$], apb_sel[$]}, {32'h0002_F004, 4'b0010});
      s = apb_addr.size();
      wr(32'h0001_F0F8, 4'd3);
      chk("incr_addrs", {apb_addr[s], apb_addr[s+1], apb_addr[s+2], apb_addr[s+3]},
          {32'h0001_F0F8, 32'h0001_F0FC, 32'h0001_F100, 32'h0001_F104});
      chk("incr_pwdata2", apb_wd[s+2], 32'hC0DE_0002);
      chk("incr_bresp", b_resp, 2'b00);
      chk("incr_latency", dly, 12);
      s = apb_addr.size();
      pc = psel_cyc;
      prdata_i = 32'h5A5A_0003;
      rd(32'h0003_F008, 4'd3, 3'd2, 2'b10);
`ifdef AXI2APB_WRAP_EN
      chk("wrap_addrs", {apb_addr[s], apb_addr[s+1], apb_addr[s+2], apb_addr[s+3]},
          {32'h0003_F008, 32'h0003_F00C, 32'h0003_F000, 32'h0003_F004});
      chk("wrap_resps", {r_resp[0], r_resp[1], r_resp[2], r_resp[3]}, 8'h00);
      chk("wrap_rdata", r_data[2], 32'h5A5A_0003);
`else
      chk("wrap_off_resps", {r_resp[0], r_resp[1], r_resp[2], r_resp[3]}, 8'b10101010);
      chk("wrap_off_nopsel", psel_cyc - pc, 0);
      chk("wrap_off_rdata", r_data[1], 32'h0);
`endif
      chk("wrap_rlast", {r_last[0], r_last[1], r_last[2], r_last[3]}, 4'b0001);
      pc = psel_cyc;
      wr(32'h0005_0000, 4'd0);
      chk("decerr_bresp", b_resp, 2'b11);
      chk("decerr_nopsel", psel_cyc - pc, 0);
      prdata_i = 32'h0BAD_CAFE;
      rd(32'h0004_FFFC, 4'd1, 3'd2, 2'b01);
      chk("edge_beat0", {r_resp[0], r_data[0], r_last[0], apb_sel[$]}, {2'b00, 32'h0BAD_CAFE, 1'b0, 4'b1000});
      chk("edge_beat1", {r_resp[1], r_data[1], r_last[1]}, {2'b11, 32'h0, 1'b1});
      pc = psel_cyc;
      rd(32'h0001_F000, 4'd0, 3'd3, 2'b01);
      chk("size_err", {r_resp[0], r_data[0], r_last[0]}, {2'b10, 32'h0, 1'b1});
      chk("size_err_nopsel", psel_cyc - pc, 0);
      hold_low = 1'b1;
      rd(32'h0001_F000, 4'd0, 3'd2, 2'b01);
      hold_low = 1'b0;
      chk("timeout_latency", dly, 17);
      chk("timeout_beat", {r_resp[0], r_data[0]}, {2'b10, 32'h0});
      err_at = apb_n + 1;
      wr(32'h0001_F000, 4'd3);
      err_at = -1;
      chk("pslverr_bresp", b_resp, 2'b10);
      hold_low = 1'b1;
      arid_i = 4'h7; araddr_i = 32'h0002_F000; arlen_i = 0; arsize_i = 3'd2; arburst_i = 2'b01; arvalid_i = 1'b1;
      #1;
      for (int i = 0; i < 20 && !arready_o; i++) tick;
      tick;
      arvalid_i = 1'b0;
      for (int i = 0; i < 20 && !penable_o; i++) tick;
      chk("mid_access", {penable_o, psel_o}, {1'b1, 4'b0010});
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", outs, '0);
      tick;
      rst_n = 1'b1;
      hold_low = 1'b0;
      tick;
      prdata_i = 32'hA5A5_0001;
      rd(32'h0002_F004, 4'd0, 3'd2, 2'b01);
      chk("post_reset_read", {r_resp[0], r_data[0], dly}, {2'b00, 32'hA5A5_0001, 32'd2});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi2apb_multi_bridge.md
# axi2apb_multi_bridge

Parametrised AXI3-subset slave to APB4 master bridge for the peripheral subsystem. It decodes each beat's address against a configurable table of NUM_SLV APB regions. Unmapped beats return DECERR rather than being redirected to a default slave. It executes FIXED/INCR/WRAP bursts one APB transfer per beat, arbitrates read and write round-robin, and bounds every APB access with a PREADY timeout.

## Interface
- ADDR_WIDTH, 32, address width (AXI and APB).
- DATA_WIDTH, 32, data width; 32 or 64.
- ID_WIDTH, 4, AXI ID width.
- NUM_SLV, 4, APB slave count (1..16).
- SLV_BASE, {32'h0004_F000, 32'h0003_F000, 32'h0002_F000, 32'h0001_F000}, packed NUM_SLV×ADDR_WIDTH region bases; slot i = slave i.
- SLV_MASK, 32'hFFFF_F000, common region mask; hit i when (addr & SLV_MASK) == SLV_BASE[i].
- TIMEOUT_CYC, 16, max ACCESS cycles before the beat is forced to SLVERR; width = $clog2(TIMEOUT_CYC+1).
- Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- awid_i/awaddr_i/awlen_i[3:0]/awsize_i[2:0]/awburst_i[1:0]/awvalid_i  in; awready_o  out  1  write address.
- wdata_i  in  DATA_WIDTH; wstrb_i  in  DATA_WIDTH/8; wlast_i, wvalid_i  in  1; wready_o  out  1  write data.
- bid_o  out  ID_WIDTH; bresp_o  out  2; bvalid_o  out  1; bready_i  in  1  write response.
- arid_i/araddr_i/arlen_i/arsize_i/arburst_i/arvalid_i  in; arready_o  out  1  read address.
- rid_o  out  ID_WIDTH; rdata_o  out  DATA_WIDTH; rresp_o  out  2; rlast_o, rvalid_o  out  1; rready_i  in  1  read data.
- paddr_o  out  ADDR_WIDTH; pwdata_o  out  DATA_WIDTH; pstrb_o  out  DATA_WIDTH/8; pwrite_o, penable_o  out  1; psel_o  out  NUM_SLV one-hot.
- prdata_i  in  DATA_WIDTH; pready_i, pslverr_i  in  1  (selected slave's muxed response).

## Operation
- FSM: IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP. One transaction outstanding.
- IDLE: if only one of arvalid/awvalid is set, grant it. If both are set, grant the one not granted last (reset preference: write). Pulse the matching ready for one cycle and capture id, addr, len, size, burst. Beat counter = 0, sticky resp = OKAY.
- WDATA: wready_o=1; on wvalid, capture wdata/wstrb and go to SETUP. wlast_i is ignored for length; awlen governs.
- Per beat, before SETUP:
  - Decode miss → no APB access; beat resp DECERR.
  - size > log2(DATA_WIDTH/8) → no APB access; beat resp SLVERR.
- SETUP: psel_o one-hot, penable_o=0, paddr/pwrite/pwdata/pstrb valid. Next cycle → ACCESS.
- ACCESS: penable_o=1. Beat completes on pready_i (resp = pslverr_i ? SLVERR : OKAY) or after TIMEOUT_CYC cycles with no pready (SLVERR). On completion, psel/penable drop.
- Read beat completion → RDATA: rvalid_o=1, rdata = prdata (0 on DECERR/SLVERR-without-access/timeout), rresp = beat resp, rlast = (count==len). Hold until rready_i.
- Write beat: sticky resp = max-severity (DECERR > SLVERR > OKAY). After last beat → BRESP, bvalid_o=1 until bready_i.
- Next address: FIXED unchanged; INCR addr + (1<<size); WRAP per Configuration; burst 2'b11 treated as INCR. Arithmetic modulo 2^ADDR_WIDTH.

## Timing
- Reset: all outputs 0, state IDLE, arbitration preference = write. Asserting rst_n mid-transaction aborts immediately; no response is issued.
- Read, zero-wait slave: AR handshake T, SETUP T+1, ACCESS T+2, rvalid T+3.
- Write: AW handshake T, wready T+1 (wvalid present), SETUP T+2, ACCESS T+3, bvalid T+4.
- Each further beat adds 3 cycles minimum, plus one per rready/wvalid stall and PREADY wait.
- Unmapped beat skips SETUP/ACCESS: read rvalid is the cycle after the decision.
- awready_o/arready_o are never high together and never high outside IDLE.

## Configuration
- AXI2APB_WRAP_EN defined: WRAP uses container = (len+1)<<size; next = (addr & ~(container-1)) | ((addr+(1<<size)) & (container-1)). Only len ∈ {1,3,7,15} is legal. Any other len → every beat SLVERR, no APB access.
- Undefined: every WRAP burst returns SLVERR on all beats (write: single bresp), no APB access. Correct beat count and rlast are kept.

## Structure
- Package axi2apb_pkg: resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11; burst enum FIXED/INCR/WRAP; state enum; function next_addr(addr,size,len,burst).
- Sub-module apb_slave_decoder: combinational addr → one-hot sel[NUM_SLV-1:0] + hit; lowest index wins on overlap.

## Test plan
- Single read 0x0002_F004, pready=1, prdata=0xA5A5_0001 → psel_o=4'b0010, rdata 0xA5A5_0001, OKAY, rlast=1, rvalid at T+3.
- INCR write len=3, size=2, addr 0x0001_F0F8 → paddr F0F8, F0FC, F100, F104; one bresp OKAY.
- WRAP read len=3 at 0x0003_F008 (macro on) → paddr 008, 00C, 000, 004. Macro off → 4 beats SLVERR, psel never asserted.
- Write to 0x0005_0000 → no psel, bresp DECERR. Read burst len=1 crossing a region edge → beat0 OKAY, beat1 DECERR.
- pready held 0 → SLVERR after 16 ACCESS cycles. pslverr=1 on beat 2 of a 4-beat write → bresp SLVERR.
- AW and AR valid together twice in succession → write then read. rst_n low mid-ACCESS → all outputs 0 in the same cycle.
